// File: rtl/acc_pkg.sv
// Shared types and constants for the result block accumulator.
// The log2 helper sizes the sample counter and the mean shift from COUNT.
package acc_pkg;

   localparam int ACC_DATA_W = 16;
   localparam int ACC_COUNT  = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

   function automatic int acc_log2(input int n);
      return $clog2(n);
   endfunction

   localparam int ACC_COUNT_LOG2 = acc_log2(ACC_COUNT);

endpackage

// File: rtl/result_block_accumulator.sv
// Sums COUNT products per block and presents sum/mean over valid/ready.
// Result is valid one edge after the last sample; in_ready drops while a result is held.
// Optional max-sample tracking is enabled by defining ACC_PEAK_EN.
module result_block_accumulator
   import acc_pkg::*;
#(
   parameter int DATA_W = ACC_DATA_W,
   parameter int COUNT  = ACC_COUNT
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [DATA_W+$clog2(COUNT)-1:0]    sum_out,
   output logic [DATA_W-1:0]                  mean_out,
   output logic                               out_valid,
   input  logic                               out_ready
`ifdef ACC_PEAK_EN
   ,
   output logic [DATA_W-1:0]                  peak_out
`endif
);

   localparam int LW = acc_log2(COUNT);
   localparam int SW = DATA_W + LW;

   acc_state_e          state_q;
   logic [SW-1:0]       acc_q;
   logic [SW-1:0]       acc_d;
   logic [SW-1:0]       sum_q;
   logic [DATA_W-1:0]   mean_q;
   logic [LW-1:0]       cnt_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                take;
   logic                last;

   assign take  = in_valid & in_ready_q;
   assign last  = (cnt_q == LW'(COUNT - 1));
   assign acc_d = acc_q + SW'(in_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         mean_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (take) begin
                  if (last) begin
                     sum_q       <= acc_d;
                     mean_q      <= DATA_W'(acc_d >> LW);
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= HOLD;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + LW'(1);
                  end
               end
            end
            HOLD: begin
               // Result stays on sum/mean after handoff; only the valid flag drops.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum_out   = sum_q;
   assign mean_out  = mean_q;

`ifdef ACC_PEAK_EN
   logic [DATA_W-1:0] peak_q;
   logic [DATA_W-1:0] peak_d;
   logic [DATA_W-1:0] peak_out_q;

   // Strict compare: an equal sample leaves the stored peak untouched.
   assign peak_d = (in_data > peak_q) ? in_data : peak_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q     <= '0;
         peak_out_q <= '0;
      end else if (take) begin
         if (last) begin
            peak_out_q <= peak_d;
            peak_q     <= '0;
         end else begin
            peak_q <= peak_d;
         end
      end
   end

   assign peak_out = peak_out_q;
`endif

endmodule

// File: tb/tb_result_block_accumulator.sv
// Scoreboard bench for result_block_accumulator (COUNT=4, DATA_W=16).
module tb_result_block_accumulator;

   typedef struct packed {
      logic [17:0] sum;
      logic [15:0] mean;
      logic [15:0] peak;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] sum_out;
   logic [15:0] mean_out;
   logic        out_valid;
   logic        out_ready;
`ifdef ACC_PEAK_EN
   logic [15:0] peak_out;
`endif

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   result_block_accumulator #(.DATA_W(16), .COUNT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .mean_out  (mean_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ACC_PEAK_EN
      ,
      .peak_out  (peak_out)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [15:0] v);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t == 50) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic exp_t mk(input logic [17:0] s, input logic [15:0] m, input logic [15:0] p);
      exp_t e;
      e.sum  = s;
      e.mean = m;
      e.peak = p;
      return e;
   endfunction

   // Monitor: pops one expected result per observed result handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("in_ready_vs_out_valid", {31'd0, in_ready}, {31'd0, ~out_valid});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("sum_out", {14'd0, sum_out}, {14'd0, e.sum});
                  check("mean_out", {16'd0, mean_out}, {16'd0, e.mean});
`ifdef ACC_PEAK_EN
                  check("peak_out", {16'd0, peak_out}, {16'd0, e.peak});
`endif
               end
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {14'd0, sum_out}, 32'd0);
      check("rst_mean", {16'd0, mean_out}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // 1: back-to-back block, single-cycle valid
      exp_q.push_back(mk(18'd100, 16'd25, 16'd40));
      send(16'd10); send(16'd20); send(16'd30); send(16'd40);
      check("t1_valid_high", {31'd0, out_valid}, 32'd1);
      check("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
      idle(1);
      check("t1_valid_one_cycle", {31'd0, out_valid}, 32'd0);

      // 2: full-scale inputs
      exp_q.push_back(mk(18'h3FFFC, 16'hFFFF, 16'hFFFF));
      repeat (4) send(16'hFFFF);
      idle(1);

      // 3: stalled result, ignored inputs, clean restart
      out_ready = 1'b0;
      exp_q.push_back(mk(18'd10, 16'd2, 16'd4));
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      in_valid = 1'b1;
      in_data  = 16'd7;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
         check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("t3_hold_sum", {14'd0, sum_out}, 32'd10);
         check("t3_hold_mean", {16'd0, mean_out}, 32'd2);
         idle(1);
      end
      out_ready = 1'b1;
      idle(1);
      in_valid = 1'b0;
      check("t3_released", {31'd0, out_valid}, 32'd0);
      exp_q.push_back(mk(18'd32, 16'd8, 16'd8));
      repeat (4) send(16'd8);
      idle(1);

      // 4: reset mid-block discards partial sum
      send(16'd100); send(16'd200);
      #3;
      rst_n = 1'b0;
      #1;
      check("t4_rst_sum", {14'd0, sum_out}, 32'd0);
      check("t4_rst_mean", {16'd0, mean_out}, 32'd0);
      check("t4_rst_valid", {31'd0, out_valid}, 32'd0);
      check("t4_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      exp_q.push_back(mk(18'd10, 16'd2, 16'd4));
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      idle(1);

      // 5: idle gaps between samples
      exp_q.push_back(mk(18'd20, 16'd5, 16'd5));
      send(16'd5); idle(2);
      send(16'd5); idle(1);
      send(16'd5); idle(3);
      check("t5_no_early_valid", {31'd0, out_valid}, 32'd0);
      send(16'd5);
      check("t5_valid_next_edge", {31'd0, out_valid}, 32'd1);
      idle(1);

`ifdef ACC_PEAK_EN
      // 6: peak tracking and clearing between blocks
      exp_q.push_back(mk(18'd621, 16'd155, 16'd300));
      send(16'd9); send(16'd300); send(16'd300); send(16'd12);
      idle(1);
      exp_q.push_back(mk(18'd5, 16'd1, 16'd2));
      send(16'd1); send(16'd1); send(16'd1); send(16'd2);
      idle(1);
`endif

      idle(3);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
